// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receive and transmit blocks.
package uart_pkg;

  // Encoding is shared with uart_tx, so these values must not be renumbered.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input. The reset value is a parameter.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always assigned with <=, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: midpoint-qualified start, LSB-first data, stop check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  // s_reg must be wide enough for both a data bit and the full stop span.
  localparam int SW = ($clog2(SB_TICK) > $clog2(OVERSAMPLE)) ? $clog2(SB_TICK)
                                                             : $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic            rx_s;
  state_t          state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [DBIT-1:0] dout_next;
  logic            ferr_next;
  logic            done_next;

  // The line resets to idle-high, so reset cannot look like a start edge.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (rx),
    .q      (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      rx_dout      <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= s_next;
      n_reg        <= n_next;
      b_reg        <= b_next;
      rx_dout      <= dout_next;
      frame_err    <= ferr_next;
      rx_done_tick <= done_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    dout_next  = rx_dout;
    ferr_next  = frame_err;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          s_next     = '0;
          state_next = START;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_reg == SW'(MID_TICK)) begin
            if (!rx_s) begin
              s_next     = '0;
              n_next     = '0;
              state_next = DATA;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_reg == SW'(OVERSAMPLE - 1)) begin
            s_next = '0;
            b_next = {rx_s, b_reg[DBIT-1:1]};
            if (n_reg == NW'(DBIT - 1)) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_reg == SW'(SB_TICK - 1)) begin
            dout_next  = b_reg;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
